full_adder_bist: RTL and testbench
==================================

FULL_ADDER_BIST -- requirements
Module: full_adder_bist

Interface
REQ-001 Parameter: HOLD_CYCLES, default 1, number of clock cycles each test vector is held before the response is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle request to begin an exhaustive test run.
REQ-005 abort  input  1  synchronous request to cancel a run in progress.
REQ-006 dut_a, dut_b, dut_cin  output  1 each  registered stimulus driven to the full-adder under test.
REQ-007 dut_sum, dut_cout  input  1 each  combinational response from the full-adder under test.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  one-cycle pulse marking run completion.
REQ-010 pass  output  1  run result: 1 = zero mismatches; valid from the done cycle until the next accepted start.
REQ-011 err_count  output  4  number of mismatching vectors in the last run (0..8).
REQ-012 first_fail_vec  output  3  index of the first mismatching vector; meaningful only when err_count != 0.

Function
REQ-013 FSM states SHALL be IDLE, APPLY, CHECK and DONE.
REQ-014 IDLE: dut_a/dut_b/dut_cin = 0, busy = 0; the FSM stays in IDLE until start = 1.
REQ-015 Start acceptance: on a clock edge with start = 1 in IDLE, the block SHALL clear err_count, pass and first_fail_vec, set vector index i = 0, and enter APPLY.
REQ-016 Stimulus order: {dut_a, dut_b, dut_cin} SHALL equal i (dut_a = MSB), with i stepping 0, 1, ..., 7 exactly once each.
REQ-017 APPLY: each vector SHALL be driven for exactly HOLD_CYCLES consecutive cycles; a hold counter counts from 0 to HOLD_CYCLES-1.
REQ-018 CHECK: dut_sum and dut_cout SHALL be sampled on the rising edge that ends the last hold cycle of each vector.
REQ-019 Expected values: sum = a^b^cin; cout = (a&b)|(a&cin)|(b&cin).
REQ-020 Mismatch: if either sampled output differs from its expected value, err_count SHALL increment by 1; on the first mismatch of a run, first_fail_vec SHALL capture i.
REQ-021 After vector 7 is sampled, the FSM SHALL enter DONE for exactly one cycle with done = 1, busy = 0 and pass = (err_count == 0), then return to IDLE.
REQ-022 busy SHALL be 1 from the cycle after start acceptance through the last hold cycle of vector 7, i.e. for 8*HOLD_CYCLES cycles; done SHALL assert in cycle 8*HOLD_CYCLES+1 after acceptance.
REQ-023 start SHALL be ignored outside IDLE, including during the DONE cycle.
REQ-024 abort = 1 in APPLY or CHECK SHALL return the FSM to IDLE on the next edge: stimulus = 0, busy = 0, no done pulse, pass = 0; err_count and first_fail_vec keep their partial values.
REQ-025 abort SHALL be ignored in IDLE and DONE; start and abort asserted together in IDLE SHALL do nothing.
REQ-026 pass, err_count and first_fail_vec SHALL hold their values in IDLE until the next accepted start.
REQ-027 err_count SHALL NOT wrap; its maximum value is 8.

Reset
REQ-028 rst_n = 0 SHALL immediately (asynchronously) force state IDLE, i = 0, hold counter = 0, and all outputs to 0: dut_a, dut_b, dut_cin, busy, done, pass, err_count and first_fail_vec.
REQ-029 Reset asserted mid-run SHALL abandon the run with no done pulse; after rst_n rises, operation SHALL resume only on a new start.

Verification
REQ-030 Golden full-adder connected, HOLD_CYCLES = 1, start pulse -> vectors 000..111 on consecutive cycles, done in cycle 9, pass = 1, err_count = 0.
REQ-031 DUT with sum stuck at 0 -> mismatches at vectors 1, 2, 4 and 7; err_count = 4, first_fail_vec = 1, pass = 0.
REQ-032 DUT with cout inverted -> err_count = 8, first_fail_vec = 0, pass = 0.
REQ-033 HOLD_CYCLES = 3 -> each vector held 3 cycles, busy high for 24 cycles, done in cycle 25.
REQ-034 start re-pulsed during a run -> ignored, run timing unchanged; abort during vector 3 -> busy = 0 next cycle, no done pulse, stimulus = 000.
REQ-035 rst_n pulsed low mid-run -> all outputs 0 without waiting for a clock edge; a subsequent start runs a complete, correct test.

Source files
------------

// File: rtl/full_adder_bist.sv
// Exhaustive built-in self test for a single-bit full adder: walks all eight
// input vectors, holds each for HOLD_CYCLES clocks and tallies mismatches.
module full_adder_bist #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_cin,
    input  logic       dut_sum,
    input  logic       dut_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_vec
);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    // CHECK is the last hold cycle of a vector, so with a single-cycle hold
    // every vector lives entirely in CHECK and APPLY is skipped.
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam state_t     VEC_FIRST = (HOLD_CYCLES == 1) ? CHECK : APPLY;

    state_t     state, state_nx;
    logic [2:0] vec, vec_nx;
    logic [3:0] hold, hold_nx;
    logic [2:0] stim, stim_nx;
    logic [3:0] err_nx;
    logic [2:0] ffv_nx;
    logic       pass_nx;
    logic       exp_sum, exp_cout, mismatch;

    assign exp_sum  = ^stim;
    assign exp_cout = (stim[2] & stim[1]) | (stim[2] & stim[0]) | (stim[1] & stim[0]);
    assign mismatch = (dut_sum != exp_sum) || (dut_cout != exp_cout);

    assign {dut_a, dut_b, dut_cin} = stim;
    assign busy = (state == APPLY) || (state == CHECK);
    assign done = (state == DONE);

    always_comb begin
        state_nx = state;
        vec_nx   = vec;
        hold_nx  = hold;
        err_nx   = err_count;
        ffv_nx   = first_fail_vec;
        pass_nx  = pass;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = VEC_FIRST;
                    vec_nx   = 3'd0;
                    hold_nx  = 4'd0;
                    err_nx   = 4'd0;
                    ffv_nx   = 3'd0;
                    pass_nx  = 1'b0;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_nx = IDLE;
                    vec_nx   = 3'd0;
                    hold_nx  = 4'd0;
                    pass_nx  = 1'b0;
                end else begin
                    hold_nx = hold + 4'd1;
                    if (hold + 4'd1 == HOLD_LAST)
                        state_nx = CHECK;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_nx = IDLE;
                    vec_nx   = 3'd0;
                    hold_nx  = 4'd0;
                    pass_nx  = 1'b0;
                end else begin
                    if (mismatch) begin
                        if (err_count == 4'd0)
                            ffv_nx = vec;
                        if (err_count != 4'd8)
                            err_nx = err_count + 4'd1;
                    end
                    hold_nx = 4'd0;
                    if (vec == 3'd7) begin
                        state_nx = DONE;
                        vec_nx   = 3'd0;
                        pass_nx  = !mismatch && (err_count == 4'd0);
                    end else begin
                        state_nx = VEC_FIRST;
                        vec_nx   = vec + 3'd1;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
        endcase
        stim_nx = (state_nx == APPLY || state_nx == CHECK) ? vec_nx : 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            vec            <= 3'd0;
            hold           <= 4'd0;
            stim           <= 3'd0;
            err_count      <= 4'd0;
            first_fail_vec <= 3'd0;
            pass           <= 1'b0;
        end else begin
            state          <= state_nx;
            vec            <= vec_nx;
            hold           <= hold_nx;
            stim           <= stim_nx;
            err_count      <= err_nx;
            first_fail_vec <= ffv_nx;
            pass           <= pass_nx;
        end
    end

endmodule

// File: tb/tb_full_adder_bist.sv
// Scoreboard bench: two BIST instances (hold 1 and hold 3) driving full adders
// with injectable per-vector sum/cout faults.
module tb_full_adder_bist;

    typedef struct packed {
        int         abort_k;
        logic [3:0] err;
        logic [2:0] first;
    } exp_t;

    logic       clk, rst_n, start, abort;
    logic [7:0] fs, fc;
    logic       a_w[2], b_w[2], c_w[2], sum_w[2], cout_w[2];
    logic       busy_w[2], done_w[2], pass_w[2];
    logic [3:0] err_w[2];
    logic [2:0] ffv_w[2];

    exp_t exp_mem[2][64];
    int   wr[2], rd[2];
    int   checks, errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Expected outcome from the fault masks: a vector fails iff it was sampled
    // and either of its outputs is faulted.
    function automatic exp_t mk(input int h, input logic [7:0] s, input logic [7:0] c,
                                input int ak);
        exp_t e;
        e.abort_k = ak;
        e.err     = 4'd0;
        e.first   = 3'd0;
        for (int v = 7; v >= 0; v--)
            if ((ak == 0 || (v + 1) * h < ak) && (s[v] || c[v])) begin
                e.err   = e.err + 4'd1;
                e.first = 3'(v);
            end
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int H = (g == 0) ? 1 : 3;
        logic [2:0] v;
        logic [1:0] tot;
        int         cyc;
        bit         act;
        exp_t       e;
        string      p;

        assign v          = {a_w[g], b_w[g], c_w[g]};
        assign tot        = 2'(a_w[g]) + 2'(b_w[g]) + 2'(c_w[g]);
        assign sum_w[g]   = tot[0] ^ fs[v];
        assign cout_w[g]  = tot[1] ^ fc[v];

        full_adder_bist #(.HOLD_CYCLES(H)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
            .dut_a(a_w[g]), .dut_b(b_w[g]), .dut_cin(c_w[g]),
            .dut_sum(sum_w[g]), .dut_cout(cout_w[g]),
            .busy(busy_w[g]), .done(done_w[g]), .pass(pass_w[g]),
            .err_count(err_w[g]), .first_fail_vec(ffv_w[g])
        );

        initial begin
            act = 0;
            cyc = 0;
            p   = $sformatf("u%0d.", H);
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                act   = 0;
                rd[g] = wr[g];
            end else if (busy_w[g]) begin
                if (!act) begin
                    act = 1;
                    cyc = 0;
                end
                cyc++;
                chk({p, "stim"}, int'(v), (cyc - 1) / H);
            end else if (act) begin
                act = 0;
                if (rd[g] == wr[g]) begin
                    chk({p, "run_without_expectation"}, 1, 0);
                end else begin
                    e = exp_mem[g][rd[g] % 64];
                    rd[g]++;
                    chk({p, "stim_after"}, int'(v), 0);
                    chk({p, "err_count"}, int'(err_w[g]), int'(e.err));
                    if (e.err != 0)
                        chk({p, "first_fail_vec"}, int'(ffv_w[g]), int'(e.first));
                    if (e.abort_k == 0) begin
                        chk({p, "done"}, int'(done_w[g]), 1);
                        chk({p, "busy_len"}, cyc, 8 * H);
                        chk({p, "pass"}, int'(pass_w[g]), int'(e.err == 0));
                    end else begin
                        chk({p, "abort_done"}, int'(done_w[g]), 0);
                        chk({p, "abort_busy_len"}, cyc, e.abort_k);
                        chk({p, "abort_pass"}, int'(pass_w[g]), 0);
                    end
                end
            end else begin
                chk({p, "idle_done"}, int'(done_w[g]), 0);
                chk({p, "idle_stim"}, int'(v), 0);
            end
        end
    end

    task automatic push(input logic [7:0] s, input logic [7:0] c, input int ak);
        exp_mem[0][wr[0] % 64] = mk(1, s, c, ak);
        wr[0]++;
        exp_mem[1][wr[1] % 64] = mk(3, s, c, ak);
        wr[1]++;
    endtask

    task automatic check_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk({tag, "_busy"}, int'(busy_w[g]), 0);
            chk({tag, "_done"}, int'(done_w[g]), 0);
            chk({tag, "_pass"}, int'(pass_w[g]), 0);
            chk({tag, "_err"}, int'(err_w[g]), 0);
            chk({tag, "_ffv"}, int'(ffv_w[g]), 0);
            chk({tag, "_stim"}, int'({a_w[g], b_w[g], c_w[g]}), 0);
        end
    endtask

    // One run on both instances; start pulses issued mid-run and in the
    // hold-1 instance's DONE cycle must be ignored.
    task automatic run(input logic [7:0] s, input logic [7:0] c, input int abort_k,
                       input bit restart);
        fs = s;
        fc = c;
        push(s, c, abort_k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cy = 1; cy <= 27; cy++) begin
            abort = (cy == abort_k);
            start = restart && (cy == 3 || cy == 9);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
        for (int g = 0; g < 2; g++)
            chk($sformatf("u%0d.pending_results", g), wr[g] - rd[g], 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wr     = '{0, 0};
        rd     = '{0, 0};
        fs     = 8'h00;
        fc     = 8'h00;
        start  = 1'b0;
        abort  = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run(8'h00, 8'h00, 0, 0);          // golden adder
        run(8'b1001_0110, 8'h00, 0, 0);   // sum stuck at 0
        run(8'h00, 8'hFF, 0, 0);          // cout inverted
        for (int n = 0; n < 6; n++)
            run(8'($urandom), (n % 2 == 0) ? 8'h00 : 8'($urandom), 0, 0);
        run(8'h00, 8'h00, 0, 1);          // ignored re-starts
        run(8'b0000_0101, 8'b0100_0000, 4, 0);  // abort on vector 3 of hold-1 run
        run(8'($urandom), 8'($urandom), 0, 1);

        // start with abort in IDLE is a no-op
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("u1.start_abort_busy", int'(busy_w[0]), 0);
        chk("u3.start_abort_busy", int'(busy_w[1]), 0);

        // asynchronous reset in the middle of a run
        fs = 8'h00;
        fc = 8'h00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_zero("midrun_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("u1.post_reset_busy", int'(busy_w[0]), 0);
        chk("u3.post_reset_busy", int'(busy_w[1]), 0);
        run(8'b0010_0000, 8'b0000_1000, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
